// File: rtl/wb_pkg.sv
// Shared types and sizes for the 64-bit writeback stage.
package wb_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned NREG  = 32;
  localparam int unsigned REG_W = $clog2(NREG);

  typedef logic [REG_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]  xlen_t;

  // Result source picked by the arbiter in a given cycle
  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_ALU  = 2'd1,
    WB_LD   = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending bits: set when decode issues a writer, cleared when
// that writer's result is committed. x0 is never pending.
module wb_scoreboard
  import wb_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     issue_valid_i,
  input  reg_idx_t issue_rd_i,
  output logic     issue_ready_o,
  input  logic     commit_valid_i,
  input  reg_idx_t commit_rd_i,
  input  reg_idx_t rs1_i,
  input  reg_idx_t rs2_i,
  output logic     rs1_pending_o,
  output logic     rs2_pending_o
);

  logic [NREG-1:0] pending_q, pending_d;

  // Lookups; a second writer to a pending register is held off (WAW)
  always_comb begin
    issue_ready_o = !pending_q[issue_rd_i];
    rs1_pending_o = pending_q[rs1_i];
    rs2_pending_o = pending_q[rs2_i];
  end

  // Next pending vector: commit clear and issue set can hit different bits on one edge
  always_comb begin
    pending_d = pending_q;
    if (commit_valid_i) begin
      pending_d[commit_rd_i] = 1'b0;
    end
    if (issue_valid_i && issue_ready_o) begin
      pending_d[issue_rd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Pending state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

`ifndef SYNTHESIS
  // A result for a register nobody issued means a producer is misbehaving
  always @(posedge clk) begin
    if (!reset && commit_valid_i && (commit_rd_i != '0)) begin
      assert (pending_q[commit_rd_i])
        else $error("wb_scoreboard: result for non-pending register x%0d", commit_rd_i);
    end
  end
`endif

endmodule

// File: rtl/writeback_64.sv
// Writeback stage: load-first arbitration of ALU/load results onto the
// register-file write port, plus the pending scoreboard for hazard checks.
// Optional feature macro: WB_BYPASS_EN (forward the write port to rs1/rs2).
module writeback_64
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [REG_W-1:0]  issue_rd,
  output logic              issue_ready,
  input  logic [REG_W-1:0]  rs1,
  input  logic [REG_W-1:0]  rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              alu_valid,
  input  logic [REG_W-1:0]  alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [REG_W-1:0]  ld_rd,
  input  logic [XLEN-1:0]   ld_data,
  output logic              ld_ready,
  output logic              reg_write,
  output logic [REG_W-1:0]  w_reg,
  output logic [XLEN-1:0]   w_data
`ifdef WB_BYPASS_EN
  ,
  output logic              fwd1_valid,
  output logic [XLEN-1:0]   fwd1_data,
  output logic              fwd2_valid,
  output logic [XLEN-1:0]   fwd2_data
`endif
);

  wb_src_e  src;
  logic     accept;
  reg_idx_t sel_rd;
  xlen_t    sel_data;

  logic     reg_write_q, reg_write_d;
  reg_idx_t w_reg_q, w_reg_d;
  xlen_t    w_data_q, w_data_d;

  logic     rs1_pending, rs2_pending;

  // Fixed-priority arbiter: loads always win, the ALU waits
  always_comb begin
    src      = WB_NONE;
    sel_rd   = '0;
    sel_data = '0;
    if (ld_valid) begin
      src      = WB_LD;
      sel_rd   = ld_rd;
      sel_data = ld_data;
    end else if (alu_valid) begin
      src      = WB_ALU;
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end
  end

  assign accept    = (src != WB_NONE);
  assign ld_ready  = 1'b1;
  assign alu_ready = !ld_valid;

  // Output register next state; x0 results update w_reg/w_data but never write
  always_comb begin
    reg_write_d = accept && (sel_rd != '0);
    w_reg_d     = w_reg_q;
    w_data_d    = w_data_q;
    if (accept) begin
      w_reg_d  = sel_rd;
      w_data_d = sel_data;
    end
  end

  // Register-file write port register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write_q <= 1'b0;
      w_reg_q     <= '0;
      w_data_q    <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      w_reg_q     <= w_reg_d;
      w_data_q    <= w_data_d;
    end
  end

  assign reg_write = reg_write_q;
  assign w_reg     = w_reg_q;
  assign w_data    = w_data_q;

  wb_scoreboard u_scoreboard (
    .clk            (clk),
    .reset          (reset),
    .issue_valid_i  (issue_valid),
    .issue_rd_i     (issue_rd),
    .issue_ready_o  (issue_ready),
    .commit_valid_i (accept),
    .commit_rd_i    (sel_rd),
    .rs1_i          (rs1),
    .rs2_i          (rs2),
    .rs1_pending_o  (rs1_pending),
    .rs2_pending_o  (rs2_pending)
  );

`ifdef WB_BYPASS_EN
  // Bypass the value being written this cycle so decode need not stall
  always_comb begin
    fwd1_valid = reg_write_q && (w_reg_q == rs1);
    fwd2_valid = reg_write_q && (w_reg_q == rs2);
    fwd1_data  = w_data_q;
    fwd2_data  = w_data_q;
    rs1_busy   = rs1_pending && !fwd1_valid;
    rs2_busy   = rs2_pending && !fwd2_valid;
  end
`else
  // Without bypass, decode waits for the register-file write to land
  always_comb begin
    rs1_busy = rs1_pending;
    rs2_busy = rs2_pending;
  end
`endif

endmodule

// File: tb/tb_writeback_64.sv
// Scoreboard bench for writeback_64: directed scenarios followed by random
// issue/result traffic checked against a pending-set reference model.
module tb_writeback_64;
  import wb_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic             issue_valid;
  logic [REG_W-1:0] issue_rd;
  logic             issue_ready;
  logic [REG_W-1:0] rs1, rs2;
  logic             rs1_busy, rs2_busy;
  logic             alu_valid;
  logic [REG_W-1:0] alu_rd;
  logic [XLEN-1:0]  alu_data;
  logic             alu_ready;
  logic             ld_valid;
  logic [REG_W-1:0] ld_rd;
  logic [XLEN-1:0]  ld_data;
  logic             ld_ready;
  logic             reg_write;
  logic [REG_W-1:0] w_reg;
  logic [XLEN-1:0]  w_data;
`ifdef WB_BYPASS_EN
  logic             fwd1_valid, fwd2_valid;
  logic [XLEN-1:0]  fwd1_data, fwd2_data;
`endif

  writeback_64 dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .reg_write(reg_write), .w_reg(w_reg), .w_data(w_data)
`ifdef WB_BYPASS_EN
    , .fwd1_valid(fwd1_valid), .fwd1_data(fwd1_data)
    , .fwd2_valid(fwd2_valid), .fwd2_data(fwd2_data)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected write-port contents, tagged with the cycle they must appear in
  typedef struct {
    int          due;
    bit          we;
    int          rd;
    logic [63:0] data;
  } exp_t;
  exp_t expq[$];

  // Reference model: set of registers with an outstanding writer
  bit          pend [NREG];
  int          outstanding[$];
  bit          prev_we;
  int          prev_rd;
  logic [63:0] prev_data;

  task automatic model_clear();
    for (int i = 0; i < int'(NREG); i++) pend[i] = 1'b0;
    outstanding.delete();
    expq.delete();
    prev_we   = 1'b0;
    prev_rd   = 0;
    prev_data = '0;
  endtask

  // One clock cycle of stimulus; predicts combinational outputs and queues the write
  task automatic drive_cycle(input bit iv, input int ird, input int r1, input int r2,
                             input bit lv, input int lrd, input logic [63:0] ldat,
                             input bit av, input int ard, input logic [63:0] adat,
                             output bit alu_acc);
    bit e_ir, e_ar, e_b1, e_b2, f1, f2, acc;
    int crd;
    logic [63:0] cdat;
    @(posedge clk);
    #1;
    issue_valid = iv;  issue_rd = reg_idx_t'(ird);
    rs1 = reg_idx_t'(r1); rs2 = reg_idx_t'(r2);
    ld_valid = lv;     ld_rd = reg_idx_t'(lrd);  ld_data = ldat;
    alu_valid = av;    alu_rd = reg_idx_t'(ard); alu_data = adat;

    e_ir = (ird == 0) || !pend[ird];
    e_ar = !lv;
    f1   = prev_we && (prev_rd == r1);
    f2   = prev_we && (prev_rd == r2);
`ifdef WB_BYPASS_EN
    e_b1 = pend[r1] && !f1;
    e_b2 = pend[r2] && !f2;
`else
    e_b1 = pend[r1];
    e_b2 = pend[r2];
`endif
    acc = 1'b0; crd = 0; cdat = '0;
    if (lv) begin
      acc = 1'b1; crd = lrd; cdat = ldat;
    end else if (av) begin
      acc = 1'b1; crd = ard; cdat = adat;
    end
    alu_acc = av && !lv;

    if (acc) begin
      expq.push_back('{cyc + 1, crd != 0, crd, cdat});
      if (crd != 0) begin
        pend[crd] = 1'b0;
        for (int k = outstanding.size() - 1; k >= 0; k--)
          if (outstanding[k] == crd) outstanding.delete(k);
      end
    end
    if (iv && e_ir && ird != 0) begin
      pend[ird] = 1'b1;
      outstanding.push_back(ird);
    end

    @(negedge clk);
    check("issue_ready", issue_ready, e_ir);
    check("alu_ready", alu_ready, e_ar);
    check("ld_ready", ld_ready, 1);
    check("rs1_busy", rs1_busy, e_b1);
    check("rs2_busy", rs2_busy, e_b2);
`ifdef WB_BYPASS_EN
    check("fwd1_valid", fwd1_valid, f1);
    check("fwd2_valid", fwd2_valid, f2);
    if (f1) check("fwd1_data", fwd1_data, prev_data);
    if (f2) check("fwd2_data", fwd2_data, prev_data);
`endif
    prev_we   = acc && (crd != 0);
    prev_rd   = crd;
    prev_data = cdat;
  endtask

  // Monitor: compare the write port every cycle against the scoreboard queue
  logic [4:0]  hold_reg;
  logic [63:0] hold_data;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      hold_reg  = '0;
      hold_data = '0;
    end else if (expq.size() > 0 && expq[0].due == cyc) begin
      e = expq.pop_front();
      check("reg_write", reg_write, e.we);
      check("w_reg", w_reg, e.rd);
      check("w_data", w_data, e.data);
      hold_reg  = 5'(e.rd);
      hold_data = e.data;
    end else begin
      check("reg_write_idle", reg_write, 0);
      check("w_reg_hold", w_reg, hold_reg);
      check("w_data_hold", w_data, hold_data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc, iv, lv, a_act;
    int          ird, r1, r2, lrd, a_rd, idx;
    logic [63:0] ldat, a_dat;

    reset = 1'b1;
    issue_valid = 0; issue_rd = '0; rs1 = '0; rs2 = '0;
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    ld_valid = 0; ld_rd = '0; ld_data = '0;
    model_clear();

    #22;
    check("rst_reg_write", reg_write, 0);
    check("rst_w_reg", w_reg, 0);
    check("rst_w_data", w_data, 0);
    check("rst_issue_ready", issue_ready, 1);
    reset = 1'b0;

    // Issue x5, ALU result x5 = 0x1234; rs1 watches x5
    drive_cycle(1, 5, 5, 0, 0, 0, 0, 0, 0, 0, acc);
    drive_cycle(0, 0, 5, 0, 0, 0, 0, 1, 5, 64'h1234, acc);
    drive_cycle(0, 0, 5, 0, 0, 0, 0, 0, 0, 0, acc);

    // Load and ALU collide: load x3 first, ALU x4 held to next cycle
    drive_cycle(1, 3, 3, 4, 0, 0, 0, 0, 0, 0, acc);
    drive_cycle(1, 4, 3, 4, 0, 0, 0, 0, 0, 0, acc);
    drive_cycle(0, 0, 3, 4, 1, 3, 64'hAAAA, 1, 4, 64'hBBBB, acc);
    check("alu_held", acc, 0);
    drive_cycle(0, 0, 3, 4, 0, 0, 0, 1, 4, 64'hBBBB, acc);
    drive_cycle(0, 0, 3, 4, 0, 0, 0, 0, 0, 0, acc);

    // Second writer to x7 is blocked until x7 commits
    drive_cycle(1, 7, 7, 0, 0, 0, 0, 0, 0, 0, acc);
    drive_cycle(1, 7, 7, 0, 0, 0, 0, 0, 0, 0, acc);
    drive_cycle(1, 7, 7, 0, 0, 0, 0, 1, 7, 64'h77, acc);
    drive_cycle(1, 7, 7, 0, 0, 0, 0, 0, 0, 0, acc);
    drive_cycle(0, 0, 7, 0, 0, 0, 0, 1, 7, 64'h78, acc);
    drive_cycle(0, 0, 7, 0, 0, 0, 0, 0, 0, 0, acc);

    // x0 result is consumed without a write; x0 issue always ready
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 1, 0, 64'hFFFF, acc);
    drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, acc);

    // Commit x6 = 0x55 while rs2 watches x6 (exercises forwarding when enabled)
    drive_cycle(1, 6, 0, 6, 0, 0, 0, 0, 0, 0, acc);
    drive_cycle(0, 0, 0, 6, 1, 6, 64'h55, 0, 0, 0, acc);
    drive_cycle(0, 0, 0, 6, 0, 0, 0, 0, 0, 0, acc);

    // Reset mid-stream with x2 and x9 pending while x11 is being written
    drive_cycle(1, 2, 9, 2, 0, 0, 0, 0, 0, 0, acc);
    drive_cycle(1, 9, 9, 2, 0, 0, 0, 0, 0, 0, acc);
    drive_cycle(1, 11, 9, 2, 0, 0, 0, 0, 0, 0, acc);
    drive_cycle(0, 0, 9, 2, 1, 11, 64'hC0DE, 0, 0, 0, acc);
    @(posedge clk);
    #1;
    issue_valid = 0; ld_valid = 0; alu_valid = 0; issue_rd = 5'd9;
    #2;
    check("pre_reset_reg_write", reg_write, 1);
    check("pre_reset_rs1_busy", rs1_busy, 1);
    reset = 1'b1;
    #1;
    check("reset_reg_write", reg_write, 0);
    check("reset_w_reg", w_reg, 0);
    check("reset_w_data", w_data, 0);
    check("reset_rs1_busy", rs1_busy, 0);
    check("reset_rs2_busy", rs2_busy, 0);
    check("reset_issue_ready", issue_ready, 1);
    model_clear();
    @(negedge clk);
    #2;
    reset = 1'b0;

    // Random traffic; ALU holds its result until accepted
    a_act = 0; a_rd = 0; a_dat = '0;
    for (int i = 0; i < 1500; i++) begin
      iv  = ($urandom_range(0, 1) == 1);
      ird = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, NREG - 1));
      r1  = int'($urandom_range(0, NREG - 1));
      r2  = int'($urandom_range(0, NREG - 1));
      lv  = 0; lrd = 0;
      ldat = {$urandom, $urandom};
      if (outstanding.size() > 0 && $urandom_range(0, 2) == 0) begin
        idx = int'($urandom_range(0, outstanding.size() - 1));
        lrd = outstanding[idx];
        outstanding.delete(idx);
        lv = 1;
      end else if ($urandom_range(0, 30) == 0) begin
        lv = 1;
      end
      if (!a_act) begin
        a_dat = {$urandom, $urandom};
        if (outstanding.size() > 0 && $urandom_range(0, 1) == 1) begin
          idx = int'($urandom_range(0, outstanding.size() - 1));
          a_rd = outstanding[idx];
          outstanding.delete(idx);
          a_act = 1;
        end else if ($urandom_range(0, 30) == 0) begin
          a_rd = 0;
          a_act = 1;
        end
      end
      drive_cycle(iv, ird, r1, r2, lv, lrd, ldat, a_act, a_rd, a_dat, acc);
      if (acc) a_act = 0;
    end

    // Drain remaining writers through the load port
    for (int i = 0; i < 100 && (a_act || outstanding.size() > 0); i++) begin
      lv = 0; lrd = 0;
      if (outstanding.size() > 0) begin
        lrd = outstanding.pop_front();
        lv = 1;
      end
      drive_cycle(0, 0, 0, 0, lv, lrd, {$urandom, $urandom}, a_act, a_rd, a_dat, acc);
      if (acc) a_act = 0;
    end
    for (int i = 0; i < 3; i++)
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
    check("drain_expq_empty", expq.size(), 0);
    check("drain_outstanding", outstanding.size() + int'(a_act), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
